// File: rtl/ram8x8_arbiter_if.sv
// ram8x8_arbiter_if: one requester's valid/ready request channel and its read-response channel
interface ram8x8_arbiter_if;
    logic       valid;
    logic       ready;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       rvalid;
    logic [7:0] rdata;
    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram8x8_arbiter.sv
// ram8x8_arbiter: two-requester 8x8 RAM arbiter with hardware clear; define RAM_ARB_FIXED_PRIO_EN for fixed m0 priority
module ram8x8_arbiter (
    input  logic                   clk,
    input  logic                   rst,
    ram8x8_arbiter_if.slave        m0,
    ram8x8_arbiter_if.slave        m1,
    input  logic                   clr_start,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   ram_wr_enb,
    output logic [2:0]             ram_wr_addr,
    output logic [7:0]             ram_din,
    output logic                   ram_rd_enb,
    output logic [2:0]             ram_rd_addr,
    input  logic [7:0]             ram_dataout
);
    typedef enum logic {SERVE, CLEAR} state_t;
    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       rd_pend, rd_own, g0, g1, xfer, x_we;
    logic [2:0] x_addr;
    logic [7:0] x_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic       ptr;
    // round-robin pointer: set means m1 is favoured because m0 was granted last
    always_ff @(posedge clk)
        if (rst) ptr <= 1'b0;
        else if (g0 | g1) ptr <= g0;
`endif
    // state, clear counter, pending read response and clear-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SERVE;
            cnt      <= 3'd0;
            rd_pend  <= 1'b0;
            rd_own   <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == CLEAR) ? cnt + 3'd1 : 3'd0;
            rd_pend  <= xfer & ~x_we;
            rd_own   <= g1;
            clr_done <= (state == CLEAR) && (cnt == 3'd7);
        end
    end
    // next state: clear runs exactly eight writes then returns to serving
    always_comb
        state_nxt = (state == SERVE) ? (clr_start ? CLEAR : SERVE) : ((cnt == 3'd7) ? SERVE : CLEAR);
    // grants, RAM port drive and response routing
    always_comb begin
        clr_busy    = (state == CLEAR);
`ifdef RAM_ARB_FIXED_PRIO_EN
        g0          = ~clr_busy & m0.valid;
        g1          = ~clr_busy & m1.valid & ~m0.valid;
`else
        g0          = ~clr_busy & m0.valid & (~m1.valid | ~ptr);
        g1          = ~clr_busy & m1.valid & (~m0.valid | ptr);
`endif
        xfer        = g0 | g1;
        x_we        = g0 ? m0.we : m1.we;
        x_addr      = g0 ? m0.addr : m1.addr;
        x_wdata     = g0 ? m0.wdata : m1.wdata;
        m0.ready    = g0;
        m1.ready    = g1;
        ram_wr_enb  = clr_busy | (xfer & x_we);
        ram_wr_addr = clr_busy ? cnt : ((xfer & x_we) ? x_addr : 3'd0);
        ram_din     = (~clr_busy & xfer & x_we) ? x_wdata : 8'd0;
        ram_rd_enb  = xfer & ~x_we;
        ram_rd_addr = ram_rd_enb ? x_addr : 3'd0;
        m0.rvalid   = rd_pend & ~rd_own & ~rst;
        m1.rvalid   = rd_pend & rd_own & ~rst;
        m0.rdata    = ram_dataout;
        m1.rdata    = ram_dataout;
    end
endmodule

// File: tb/tb_ram8x8_arbiter.sv
// tb_ram8x8_arbiter: directed checks of arbitration, read/write timing, clear sequence and reset
module tb_ram8x8_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_start = 1'b0;
    logic       clr_busy, clr_done, ram_wr_enb, ram_rd_enb;
    logic [2:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_din, ram_dataout;
    logic [7:0] mem [8];
    int         errs = 0;
    int         checks = 0;

    ram8x8_arbiter_if m0_if ();
    ram8x8_arbiter_if m1_if ();

    ram8x8_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .ram_wr_enb  (ram_wr_enb),
        .ram_wr_addr (ram_wr_addr),
        .ram_din     (ram_din),
        .ram_rd_enb  (ram_rd_enb),
        .ram_rd_addr (ram_rd_addr),
        .ram_dataout (ram_dataout)
    );

    always #5 clk = ~clk;

    // behavioural 8x8 RAM with registered read
    always @(posedge clk) begin
        if (ram_wr_enb) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_enb) ram_dataout <= mem[ram_rd_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_if.valid = 1'b0; m0_if.we = 1'b0; m0_if.addr = 3'd0; m0_if.wdata = 8'd0;
        m1_if.valid = 1'b0; m1_if.we = 1'b0; m1_if.addr = 3'd0; m1_if.wdata = 8'd0;
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({clr_busy, clr_done, m0_if.rvalid, m1_if.rvalid, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, ram_din} !== 20'h0) begin
            errs++;
            $display("FAIL reset_outputs got=%h exp=0", {clr_busy, clr_done, m0_if.rvalid, m1_if.rvalid, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, ram_din});
        end
        checks++;
        if ({m0_if.ready, m1_if.ready} !== 2'b00) begin
            errs++;
            $display("FAIL reset_ready got=%b exp=00", {m0_if.ready, m1_if.ready});
        end
    endtask

    task automatic test_write_read();
        step(); idle();
        m0_if.valid = 1'b1; m0_if.we = 1'b1; m0_if.addr = 3'd3; m0_if.wdata = 8'hA5;
        #1;
        checks++;
        if ({m0_if.ready, m1_if.ready, ram_wr_enb, ram_wr_addr, ram_din, ram_rd_enb} !== {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0}) begin
            errs++;
            $display("FAIL write_accept got=%h exp=%h", {m0_if.ready, m1_if.ready, ram_wr_enb, ram_wr_addr, ram_din, ram_rd_enb}, {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0});
        end
        step(); idle();
        m1_if.valid = 1'b1; m1_if.addr = 3'd3;
        #1;
        checks++;
        if ({m0_if.ready, m1_if.ready, ram_rd_enb, ram_rd_addr, ram_wr_enb} !== {1'b0, 1'b1, 1'b1, 3'd3, 1'b0}) begin
            errs++;
            $display("FAIL read_accept got=%b exp=%b", {m0_if.ready, m1_if.ready, ram_rd_enb, ram_rd_addr, ram_wr_enb}, {1'b0, 1'b1, 1'b1, 3'd3, 1'b0});
        end
        step(); idle();
        #1;
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid, m1_if.rdata} !== {1'b0, 1'b1, 8'hA5}) begin
            errs++;
            $display("FAIL raw_response got=%h exp=%h", {m0_if.rvalid, m1_if.rvalid, m1_if.rdata}, {1'b0, 1'b1, 8'hA5});
        end
        checks++;
        if ({ram_wr_enb, ram_rd_enb} !== 2'b00) begin
            errs++;
            $display("FAIL idle_enables got=%b exp=00", {ram_wr_enb, ram_rd_enb});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g, prev;
        step(); idle();
        m0_if.valid = 1'b1; m0_if.we = 1'b1; m0_if.addr = 3'd1; m0_if.wdata = 8'h51;
        step(); idle();
        m1_if.valid = 1'b1; m1_if.we = 1'b1; m1_if.addr = 3'd2; m1_if.wdata = 8'h52;
        step(); idle();
        m0_if.valid = 1'b1; m0_if.addr = 3'd1;
        m1_if.valid = 1'b1; m1_if.addr = 3'd2;
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_g = 2'b10;
`else
            exp_g = (k % 2 == 1) ? 2'b01 : 2'b10;
`endif
            checks++;
            if ({m0_if.ready, m1_if.ready} !== exp_g) begin
                errs++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, {m0_if.ready, m1_if.ready}, exp_g);
            end
            if (k > 0) begin
                checks++;
                if ({m0_if.rvalid, m1_if.rvalid} !== prev || (prev[1] ? m0_if.rdata : m1_if.rdata) !== (prev[1] ? 8'h51 : 8'h52)) begin
                    errs++;
                    $display("FAIL rr_resp%0d got=%b/%h/%h exp=%b", k, {m0_if.rvalid, m1_if.rvalid}, m0_if.rdata, m1_if.rdata, prev);
                end
            end
            prev = exp_g;
            step();
        end
        idle();
        #1;
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid} !== prev || (prev[1] ? m0_if.rdata : m1_if.rdata) !== (prev[1] ? 8'h51 : 8'h52)) begin
            errs++;
            $display("FAIL rr_resp_last got=%b/%h/%h exp=%b", {m0_if.rvalid, m1_if.rvalid}, m0_if.rdata, m1_if.rdata, prev);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            step(); idle();
            m0_if.valid = 1'b1; m0_if.we = 1'b1; m0_if.addr = 3'(i); m0_if.wdata = 8'(8'h11 * (i + 1));
        end
        step(); idle();
        clr_start = 1'b1;
        #1;
        checks++;
        if ({clr_busy, clr_done} !== 2'b00) begin
            errs++;
            $display("FAIL clr_start_cycle got=%b exp=00", {clr_busy, clr_done});
        end
        step(); idle();
        m0_if.valid = 1'b1; m0_if.addr = 3'd0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({clr_busy, clr_done, m0_if.ready, ram_wr_enb, ram_wr_addr, ram_din, ram_rd_enb} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 8'h00, 1'b0}) begin
                errs++;
                $display("FAIL clear_cycle%0d got=%h exp=%h", i, {clr_busy, clr_done, m0_if.ready, ram_wr_enb, ram_wr_addr, ram_din, ram_rd_enb}, {1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 8'h00, 1'b0});
            end
            step();
        end
        #1;
        checks++;
        if ({clr_busy, clr_done, m0_if.ready, ram_rd_enb} !== 4'b0111) begin
            errs++;
            $display("FAIL clr_done_cycle got=%b exp=0111", {clr_busy, clr_done, m0_if.ready, ram_rd_enb});
        end
        for (int a = 1; a < 8; a++) begin
            step();
            m0_if.addr = 3'(a);
            #1;
            checks++;
            if ({m0_if.rvalid, m0_if.rdata, clr_done} !== {1'b1, 8'h00, 1'b0}) begin
                errs++;
                $display("FAIL cleared_read%0d got=%h exp=%h", a - 1, {m0_if.rvalid, m0_if.rdata, clr_done}, {1'b1, 8'h00, 1'b0});
            end
        end
        step(); idle();
        #1;
        checks++;
        if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 8'h00}) begin
            errs++;
            $display("FAIL cleared_read7 got=%h exp=%h", {m0_if.rvalid, m0_if.rdata}, {1'b1, 8'h00});
        end
    endtask

    task automatic test_clear_abort();
        int done_seen;
        step(); idle();
        m0_if.valid = 1'b1; m0_if.we = 1'b1; m0_if.addr = 3'd5; m0_if.wdata = 8'h3C;
        step(); idle();
        m1_if.valid = 1'b1; m1_if.addr = 3'd5;
        clr_start = 1'b1;
        #1;
        checks++;
        if (m1_if.ready !== 1'b1) begin
            errs++;
            $display("FAIL pre_clear_grant got=%b exp=1", m1_if.ready);
        end
        step(); idle();
        #1;
        checks++;
        if ({m1_if.rvalid, m1_if.rdata, m0_if.rvalid, clr_busy} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL pending_resp got=%h exp=%h", {m1_if.rvalid, m1_if.rdata, m0_if.rvalid, clr_busy}, {1'b1, 8'h3C, 1'b0, 1'b1});
        end
        repeat (4) step();
        checks++;
        if ({clr_busy, ram_wr_addr} !== {1'b1, 3'd4}) begin
            errs++;
            $display("FAIL clear_count4 got=%b exp=%b", {clr_busy, ram_wr_addr}, {1'b1, 3'd4});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        m1_if.valid = 1'b1; m1_if.addr = 3'd0;
        #1;
        checks++;
        if ({clr_busy, clr_done, m0_if.rvalid, m1_if.rvalid, ram_wr_enb, ram_wr_addr, ram_din} !== 14'h0) begin
            errs++;
            $display("FAIL abort_outputs got=%h exp=0", {clr_busy, clr_done, m0_if.rvalid, m1_if.rvalid, ram_wr_enb, ram_wr_addr, ram_din});
        end
        checks++;
        if (m1_if.ready !== 1'b1) begin
            errs++;
            $display("FAIL abort_grant got=%b exp=1", m1_if.ready);
        end
        done_seen = 0;
        step(); idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (clr_done !== 1'b0) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) begin
            errs++;
            $display("FAIL abort_no_done got=%0d exp=0", done_seen);
        end
    endtask

    task automatic test_reset_read();
        step(); idle();
        m0_if.valid = 1'b1; m0_if.addr = 3'd5;
        step(); idle();
        rst = 1'b1;
        #1;
        checks++;
        if (m0_if.rvalid !== 1'b0) begin
            errs++;
            $display("FAIL reset_suppress got=%b exp=0", m0_if.rvalid);
        end
        step();
        rst = 1'b0;
        m0_if.valid = 1'b1; m0_if.addr = 3'd1;
        m1_if.valid = 1'b1; m1_if.addr = 3'd2;
        #1;
        checks++;
        if ({m0_if.ready, m1_if.ready, m0_if.rvalid} !== 3'b100) begin
            errs++;
            $display("FAIL reset_ptr got=%b exp=100", {m0_if.ready, m1_if.ready, m0_if.rvalid});
        end
        step(); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_clear();
        test_clear_abort();
        test_reset_read();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
